pc_sequencer: RTL and testbench

//  Next-PC controller for the 5-stage pipeline. Produces NPC and a PC write enable for the PC register.

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_sequencer_target_mux.sv | 45 ++++
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the next-PC sequencer: FSM state encodings, the
// sequential fetch step, the J-type index width and the reset fetch address.
package pc_sequencer_pkg;

    localparam logic [1:0] PCS_RUN   = 2'd0;
    localparam logic [1:0] PCS_WAIT  = 2'd1;
    localparam logic [1:0] PCS_FLUSH = 2'd2;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam int unsigned JIDX_W = 26;

    localparam logic [31:0] PCS_INIT_ADDR = 32'hBFC0_0000;

endpackage

// File: rtl/pc_sequencer_target_mux.sv
// pc_target_mux: combinational redirect select for the next-PC sequencer.
// Priority is JR > Branch_Taken > Jump; the J target is formed from the
// upper nibble of ID PC+4 and the 26-bit index. JR support is compiled in
// only when PC_SEQ_JR_EN is defined.
module pc_target_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
`ifdef PC_SEQ_JR_EN
    input  logic              i_jr,
    input  logic [ADDR_W-1:0] i_jr_base,
`endif
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_jump,
    input  logic [JIDX_W-1:0] i_imm,
    input  logic [ADDR_W-1:0] i_id_pc4,
    output logic              o_redirect,
    output logic [ADDR_W-1:0] o_target
);

    logic [ADDR_W-1:0] w_jtarget;
    logic              w_unused;

    // Only the region bits of ID PC+4 contribute to the J target
    assign w_unused  = ^i_id_pc4[27:0];
    assign w_jtarget = {i_id_pc4[ADDR_W-1:28], i_imm, 2'b00};

    // Later assignments override earlier ones, giving the redirect priority
    always_comb begin
        o_redirect = i_branch_taken | i_jump;
        o_target   = w_jtarget;
        if (i_branch_taken) begin
            o_target = i_branch_target;
        end
`ifdef PC_SEQ_JR_EN
        o_redirect = o_redirect | i_jr;
        if (i_jr) begin
            o_target = {i_jr_base[ADDR_W-1:2], 2'b00};
        end
`endif
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 5-stage pipeline.
// Chooses between sequential fetch and redirects, applies load-use stalls,
// holds fetch while instruction memory is busy (buffering the first redirect
// seen during the wait) and drives the IF/ID flush and ID/EX bubble.
// Define PC_SEQ_JR_EN to add the JR / RegfileOut1 ports and JR redirects.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] INIT_ADDR    = PCS_INIT_ADDR[ADDR_W-1:0],
    parameter int unsigned       FLUSH_CYCLES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ID_PC4,
    input  logic              Imem_Ready,
    input  logic              Stall_Data,
    input  logic              Branch_Taken,
    input  logic [ADDR_W-1:0] Branch_Target,
    input  logic              Jump,
    input  logic [JIDX_W-1:0] Immediate,
`ifdef PC_SEQ_JR_EN
    input  logic              JR,
    input  logic [ADDR_W-1:0] RegfileOut1,
`endif
    output logic [ADDR_W-1:0] NPC,
    output logic              PC_En,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Bubble
);

    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);

    logic [1:0]        r_state;
    logic              r_pend_vld;
    logic [ADDR_W-1:0] r_pend_tgt;
    logic [2:0]        r_flush_cnt;

    logic [1:0]        w_state_nxt;
    logic              w_pend_vld_nxt;
    logic [ADDR_W-1:0] w_pend_tgt_nxt;
    logic [2:0]        w_flush_cnt_nxt;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_seq;
    logic              w_run_like;
    logic              w_apply;
    logic [ADDR_W-1:0] w_apply_tgt;

    pc_target_mux #(
        .ADDR_W (ADDR_W)
    ) u_target_mux (
`ifdef PC_SEQ_JR_EN
        .i_jr            (JR),
        .i_jr_base       (RegfileOut1),
`endif
        .i_branch_taken  (Branch_Taken),
        .i_branch_target (Branch_Target),
        .i_jump          (Jump),
        .i_imm           (Immediate),
        .i_id_pc4        (ID_PC4),
        .o_redirect      (w_redirect),
        .o_target        (w_target)
    );

    assign w_pc_seq = PC + PC_STEP[ADDR_W-1:0];

    // WAIT with memory ready and nothing buffered is handled exactly like RUN
    assign w_run_like = (r_state == PCS_RUN) ||
                        ((r_state == PCS_WAIT) && Imem_Ready && !r_pend_vld);

    // Output decode and next-state selection
    always_comb begin
        NPC             = w_pc_seq;
        PC_En           = 1'b0;
        IF_ID_Flush     = 1'b0;
        ID_EX_Bubble    = 1'b0;
        w_state_nxt     = r_state;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_tgt_nxt  = r_pend_tgt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_apply         = 1'b0;
        w_apply_tgt     = w_target;

        if (Reset) begin
            NPC          = INIT_ADDR;
            PC_En        = 1'b1;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (w_run_like) begin
            w_state_nxt = PCS_RUN;
            if (Stall_Data) begin
                // The branch re-evaluates once the hazard clears
                ID_EX_Bubble = 1'b1;
            end else if (w_redirect && Imem_Ready) begin
                w_apply = 1'b1;
            end else if (w_redirect) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_tgt_nxt = w_target;
                w_state_nxt    = PCS_WAIT;
            end else if (!Imem_Ready) begin
                w_state_nxt = PCS_WAIT;
            end else begin
                PC_En = 1'b1;
            end
        end else if (r_state == PCS_WAIT) begin
            ID_EX_Bubble = Stall_Data;
            if (Imem_Ready) begin
                w_apply        = 1'b1;
                w_apply_tgt    = r_pend_tgt;
                w_pend_vld_nxt = 1'b0;
            end else if (w_redirect && !r_pend_vld && !Stall_Data) begin
                // First redirect wins; repeats come from the same frozen ID instruction
                w_pend_vld_nxt = 1'b1;
                w_pend_tgt_nxt = w_target;
            end
        end else if (r_state == PCS_FLUSH) begin
            IF_ID_Flush = 1'b1;
            PC_En       = Imem_Ready;
            if (Imem_Ready) begin
                if (r_flush_cnt <= 3'd1) begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = PCS_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
        end else begin
            w_state_nxt = PCS_RUN;
        end

        if (w_apply) begin
            NPC             = w_apply_tgt;
            PC_En           = 1'b1;
            IF_ID_Flush     = 1'b1;
            w_state_nxt     = MULTI_FLUSH ? PCS_FLUSH : PCS_RUN;
            w_flush_cnt_nxt = MULTI_FLUSH ? FLUSH_INIT : 3'd0;
        end
    end

    // State register; reset discards any buffered redirect
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= PCS_RUN;
            r_pend_vld  <= 1'b0;
            r_pend_tgt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_tgt  <= w_pend_tgt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (FLUSH_CYCLES=1 main instance plus a
// FLUSH_CYCLES=3 instance sharing the same inputs). PC_SEQ_JR_EN adds JR tests.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam logic [31:0] INIT = 32'h0000_1000;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        rdy;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [25:0] imm;
        logic        jr;
        logic [31:0] rf;
    } stim_t;

    typedef struct {
        string       name;
        logic [34:0] val;
        logic [34:0] mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rdy, stall, br, jmp, jr;
    logic [31:0] pc, id_pc4, bt, rf;
    logic [25:0] imm;
    logic [31:0] npc, npc3;
    logic        pc_en, flush, bub, pc_en3, flush3, bub3;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W       (32),
        .INIT_ADDR    (INIT),
        .FLUSH_CYCLES (1)
    ) dut (
        .Clock (clk), .Reset (rst), .PC (pc), .ID_PC4 (id_pc4),
        .Imem_Ready (rdy), .Stall_Data (stall), .Branch_Taken (br),
        .Branch_Target (bt), .Jump (jmp), .Immediate (imm),
`ifdef PC_SEQ_JR_EN
        .JR (jr), .RegfileOut1 (rf),
`endif
        .NPC (npc), .PC_En (pc_en), .IF_ID_Flush (flush), .ID_EX_Bubble (bub)
    );

    pc_sequencer #(
        .ADDR_W       (32),
        .INIT_ADDR    (INIT),
        .FLUSH_CYCLES (3)
    ) dut3 (
        .Clock (clk), .Reset (rst), .PC (pc), .ID_PC4 (id_pc4),
        .Imem_Ready (rdy), .Stall_Data (stall), .Branch_Taken (br),
        .Branch_Target (bt), .Jump (jmp), .Immediate (imm),
`ifdef PC_SEQ_JR_EN
        .JR (jr), .RegfileOut1 (rf),
`endif
        .NPC (npc3), .PC_En (pc_en3), .IF_ID_Flush (flush3), .ID_EX_Bubble (bub3)
    );

    function automatic stim_t idle(input logic [31:0] p);
        stim_t s;
        s.rst = 1'b0; s.pc = p; s.pc4 = 32'h0; s.rdy = 1'b1; s.stall = 1'b0;
        s.br = 1'b0; s.bt = 32'h0; s.jmp = 1'b0; s.imm = 26'h0;
        s.jr = 1'b0; s.rf = 32'h0;
        return s;
    endfunction

    function automatic exp_t mk(input string n, input logic [31:0] np, input logic en,
                                input logic fl, input logic bb, input bit care_npc);
        exp_t e;
        e.name = n;
        e.val  = {np, en, fl, bb};
        e.mask = care_npc ? {32'hFFFF_FFFF, 3'b111} : {32'h0, 3'b111};
        return e;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst; pc = s.pc; id_pc4 = s.pc4; rdy = s.rdy; stall = s.stall;
        br = s.br; bt = s.bt; jmp = s.jmp; imm = s.imm; jr = s.jr; rf = s.rf;
    endtask

    task automatic test_reset();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e;
        logic [34:0] obs;
        for (int i = 0; i < 2; i++) begin
            st[i] = idle(32'hx);
            st[i].rst = 1'b1;
            ex[i] = mk("reset", INIT, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s[%0d]: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, i, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dut.r_state !== PCS_RUN) begin
            n_fail++;
            $display("FAIL reset_state: observed %0d, expected %0d", dut.r_state, PCS_RUN);
        end
        n_checks++;
        if (dut.r_pend_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pend_vld: observed %b, expected 0", dut.r_pend_vld);
        end
    endtask

    task automatic test_sequential();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e;
        logic [34:0] obs;
        st[0] = idle(32'h0000_3000); ex[0] = mk("seq_3000", 32'h0000_3004, 1, 0, 0, 1);
        st[1] = idle(32'hFFFF_FFFC); ex[1] = mk("seq_wrap", 32'h0000_0000, 1, 0, 0, 1);
        st[2] = idle(32'h7FFF_FFF8); ex[2] = mk("seq_mid",  32'h7FFF_FFFC, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_priority();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e;
        logic [34:0] obs;
        st[0] = idle(32'h0000_3008);
        st[0].br = 1; st[0].bt = 32'h0000_3040; st[0].jmp = 1;
        st[0].imm = 26'h0000_200; st[0].pc4 = 32'h0000_300C;
        ex[0] = mk("br_over_j", 32'h0000_3040, 1, 1, 0, 1);
        st[1] = idle(32'h0000_3040);
        ex[1] = mk("br_after",  32'h0000_3044, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e;
        logic [34:0] obs;
        st[0] = idle(32'h0000_3044); st[0].stall = 1; st[0].br = 1; st[0].bt = 32'h0000_3080;
        ex[0] = mk("stall_br", 32'h0, 0, 0, 1, 0);
        st[1] = idle(32'h0000_3044); st[1].br = 1; st[1].bt = 32'h0000_3080;
        ex[1] = mk("br_after_stall", 32'h0000_3080, 1, 1, 0, 1);
        st[2] = idle(32'h0000_3080);
        ex[2] = mk("seq_after_br", 32'h0000_3084, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_redirect();
        stim_t st[5];
        exp_t  ex[5];
        exp_t  e;
        logic [34:0] obs;
        for (int i = 0; i < 4; i++) begin
            st[i] = idle(32'h0000_3084);
            st[i].jmp = 1; st[i].imm = 26'h0000_100; st[i].pc4 = 32'h0000_3008;
            st[i].rdy = (i == 3);
            ex[i] = mk("wait_hold", 32'h0, 0, 0, 0, 0);
        end
        st[1].br = 1; st[1].bt = 32'h0000_5000;
        ex[3] = mk("wait_release", 32'h0000_0400, 1, 1, 0, 1);
        st[4] = idle(32'h0000_0400);
        ex[4] = mk("wait_seq", 32'h0000_0404, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                n_checks++;
                if (dut.r_pend_vld !== 1'b1 || dut.r_state !== PCS_WAIT) begin
                    n_fail++;
                    $display("FAIL wait_pending: observed pend_vld=%b state=%0d, expected pend_vld=1 state=%0d",
                             dut.r_pend_vld, dut.r_state, PCS_WAIT);
                end
            end
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s[%0d]: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, i, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_plain();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e;
        logic [34:0] obs;
        st[0] = idle(32'h0000_0404); st[0].rdy = 0;
        ex[0] = mk("plain_hold", 32'h0, 0, 0, 0, 0);
        st[1] = idle(32'h0000_0404);
        ex[1] = mk("plain_release", 32'h0000_0408, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e;
        logic [34:0] obs;
        st[0] = idle(32'h0000_3100); st[0].rdy = 0;
        st[0].jmp = 1; st[0].imm = 26'h0000_200; st[0].pc4 = 32'h0000_3104;
        ex[0] = mk("mid_wait_enter", 32'h0, 0, 0, 0, 0);
        st[1] = idle(32'h0000_3100); st[1].rdy = 0; st[1].rst = 1;
        ex[1] = mk("mid_wait_reset", INIT, 1, 1, 1, 1);
        st[2] = idle(32'h0000_3200);
        ex[2] = mk("mid_wait_after", 32'h0000_3204, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                n_checks++;
                if (dut.r_pend_vld !== 1'b0 || dut.r_state !== PCS_RUN) begin
                    n_fail++;
                    $display("FAIL mid_wait_cleared: observed pend_vld=%b state=%0d, expected pend_vld=0 state=%0d",
                             dut.r_pend_vld, dut.r_state, PCS_RUN);
                end
            end
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e;
        logic [34:0] obs;
        st[0] = idle(32'h0000_3000); st[0].br = 1; st[0].bt = 32'h0000_3100;
        ex[0] = mk("b2b_branch", 32'h0000_3100, 1, 1, 0, 1);
        st[1] = idle(32'h0000_3100); st[1].jmp = 1; st[1].imm = 26'h0000_080; st[1].pc4 = 32'h0000_3104;
        ex[1] = mk("b2b_jump", 32'h0000_0200, 1, 1, 0, 1);
        st[2] = idle(32'h0000_0200);
        ex[2] = mk("b2b_seq", 32'h0000_0204, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef PC_SEQ_JR_EN
    task automatic test_jr();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e;
        logic [34:0] obs;
        st[0] = idle(32'h0000_3204);
        st[0].jr = 1; st[0].rf = 32'h0000_3013; st[0].br = 1; st[0].bt = 32'h0000_3040; st[0].jmp = 1;
        ex[0] = mk("jr_priority", 32'h0000_3010, 1, 1, 0, 1);
        st[1] = idle(32'h0000_3010);
        ex[1] = mk("jr_seq", 32'h0000_3014, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc, pc_en, flush, bub};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_flush_multi();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e;
        logic [34:0] obs;
        st[0] = idle(32'hx); st[0].rst = 1;
        ex[0] = mk("f3_reset", INIT, 1, 1, 1, 1);
        st[1] = idle(32'h0000_5000); st[1].br = 1; st[1].bt = 32'h0000_6000;
        ex[1] = mk("f3_redirect", 32'h0000_6000, 1, 1, 0, 1);
        st[2] = idle(32'h0000_6000); st[2].br = 1; st[2].bt = 32'h0000_7000;
        ex[2] = mk("f3_flush1", 32'h0000_6004, 1, 1, 0, 1);
        st[3] = idle(32'h0000_6004); st[3].rdy = 0;
        ex[3] = mk("f3_flush_busy", 32'h0000_6008, 0, 1, 0, 1);
        st[4] = idle(32'h0000_6004);
        ex[4] = mk("f3_flush2", 32'h0000_6008, 1, 1, 0, 1);
        st[5] = idle(32'h0000_6008);
        ex[5] = mk("f3_run", 32'h0000_600C, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            obs = {npc3, pc_en3, flush3, bub3};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: observed NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b, expected NPC=%h PC_En=%b IF_ID_Flush=%b ID_EX_Bubble=%b",
                         e.name, obs[34:3], obs[2], obs[1], obs[0], e.val[34:3], e.val[2], e.val[1], e.val[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(idle(32'h0));
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_sequential();
        test_branch_priority();
        test_stall();
        test_wait_redirect();
        test_wait_plain();
        test_reset_mid_wait();
`ifdef PC_SEQ_JR_EN
        test_jr();
`endif
        test_back_to_back();
        test_flush_multi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
